// File: rtl/uart_boot_loader.sv
// uart_boot_loader
// Receives a framed program image over an 8N1 UART line and writes it
// word by word into instruction RAM. The core is held in reset until a
// complete image has arrived with a matching XOR checksum.
//
// Frame: 0xA5, LEN_LO, LEN_HI, LEN*4 data bytes (little-endian words), CSUM.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   uart_rx    in   serial input, idle high, 8N1, LSB first
//   imem_we    out  instruction RAM write strobe (one-cycle pulse)
//   imem_addr  out  word address of the write
//   imem_wdata out  write data
//   core_hold  out  1 = keep core in reset
//   done       out  image loaded and verified (sticky until rst)
//   err        out  last frame failed (sticky until the next sync byte)
//   word_cnt   out  words written in the current frame
module uart_boot_loader #(
    parameter int CLK_DIV   = 16,
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_cnt
);

    localparam logic [15:0] HALF_M1   = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL_M1   = 16'(CLK_DIV - 1);
    localparam logic [16:0] MAX_LEN   = 17'(MAX_WORDS);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {ST_SYNC, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM, ST_DONE} st_t;

    // Running checksum update: plain XOR of every data byte.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    logic      rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_t rx_state_r, rx_state_s;
    logic [15:0] rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_tick_s, byte_valid_s, frame_err_s;

    st_t         state_r, state_s;
    logic [15:0] len_r;
    logic [1:0]  byte_idx_r;
    logic [23:0] word_r;
    logic [7:0]  csum_r;
    logic        frame_start_s, len_bad_s, data_byte_s, word_wr_s;
    logic        csum_ok_s, csum_bad_s, ferr_s;

    // Two-flop synchroniser plus one delayed copy for start-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Bit-timer expiry: half a bit in START (mid-start recheck), a full bit after.
    always_comb begin
        rx_tick_s = 1'b0;
        case (rx_state_r)
            RX_START:         rx_tick_s = (rx_cnt_r == HALF_M1);
            RX_DATA, RX_STOP: rx_tick_s = (rx_cnt_r == FULL_M1);
            default:          rx_tick_s = 1'b0;
        endcase
    end

    // UART receiver next-state logic.
    always_comb begin
        rx_state_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync_r) rx_state_s = RX_START;
                else                         rx_state_s = RX_IDLE;
            end
            RX_START: begin
                // Line back high at mid-start means a glitch, not a start bit.
                if (rx_tick_s) rx_state_s = rx_sync_r ? RX_IDLE : RX_DATA;
                else           rx_state_s = RX_START;
            end
            RX_DATA: begin
                if (rx_tick_s && (rx_bit_r == 3'd7)) rx_state_s = RX_STOP;
                else                                 rx_state_s = RX_DATA;
            end
            RX_STOP: begin
                if (rx_tick_s) rx_state_s = RX_IDLE;
                else           rx_state_s = RX_STOP;
            end
            default: rx_state_s = RX_IDLE;
        endcase
    end

    // UART receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state_r <= RX_IDLE;
        else     rx_state_r <= rx_state_s;
    end

    // UART receiver bit timer, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            if ((rx_state_s != rx_state_r) || rx_tick_s) rx_cnt_r <= 16'd0;
            else                                         rx_cnt_r <= rx_cnt_r + 16'd1;
            if (rx_state_r == RX_START) begin
                rx_bit_r <= 3'd0;
            end else if ((rx_state_r == RX_DATA) && rx_tick_s) begin
                rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                rx_bit_r   <= rx_bit_r + 3'd1;
            end else begin
                rx_bit_r <= rx_bit_r;
            end
        end
    end

    assign byte_valid_s = (rx_state_r == RX_STOP) && rx_tick_s && rx_sync_r;
    assign frame_err_s  = (rx_state_r == RX_STOP) && rx_tick_s && !rx_sync_r;

    // Frame FSM next-state logic; a framing error aborts any state but DONE.
    always_comb begin
        state_s = state_r;
        if (frame_err_s && (state_r != ST_DONE)) begin
            state_s = ST_SYNC;
        end else begin
            case (state_r)
                ST_SYNC: begin
                    if (byte_valid_s && (rx_shift_r == SYNC_BYTE)) state_s = ST_LEN0;
                    else                                           state_s = ST_SYNC;
                end
                ST_LEN0: begin
                    if (byte_valid_s) state_s = ST_LEN1;
                    else              state_s = ST_LEN0;
                end
                ST_LEN1: begin
                    if (!byte_valid_s)                               state_s = ST_LEN1;
                    else if ({1'b0, rx_shift_r, len_r[7:0]} > MAX_LEN) state_s = ST_SYNC;
                    else if ({rx_shift_r, len_r[7:0]} == 16'd0)      state_s = ST_CSUM;
                    else                                             state_s = ST_DATA;
                end
                ST_DATA: begin
                    if (byte_valid_s && (byte_idx_r == 2'd3) && ((word_cnt + 16'd1) == len_r))
                        state_s = ST_CSUM;
                    else
                        state_s = ST_DATA;
                end
                ST_CSUM: begin
                    if (byte_valid_s) state_s = (rx_shift_r == csum_r) ? ST_DONE : ST_SYNC;
                    else              state_s = ST_CSUM;
                end
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_SYNC;
            endcase
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_SYNC;
        else     state_r <= state_s;
    end

    // Frame FSM output decode: one-cycle strobes for the datapath registers.
    always_comb begin
        ferr_s        = frame_err_s && (state_r != ST_DONE);
        frame_start_s = 1'b0;
        len_bad_s     = 1'b0;
        data_byte_s   = 1'b0;
        word_wr_s     = 1'b0;
        csum_ok_s     = 1'b0;
        csum_bad_s    = 1'b0;
        case (state_r)
            ST_SYNC: frame_start_s = byte_valid_s && (rx_shift_r == SYNC_BYTE);
            ST_LEN1: len_bad_s     = byte_valid_s && ({1'b0, rx_shift_r, len_r[7:0]} > MAX_LEN);
            ST_DATA: begin
                data_byte_s = byte_valid_s;
                word_wr_s   = byte_valid_s && (byte_idx_r == 2'd3);
            end
            ST_CSUM: begin
                csum_ok_s  = byte_valid_s && (rx_shift_r == csum_r);
                csum_bad_s = byte_valid_s && (rx_shift_r != csum_r);
            end
            default: frame_start_s = 1'b0;
        endcase
    end

    // Frame datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_cnt   <= 16'd0;
            len_r      <= 16'd0;
            byte_idx_r <= 2'd0;
            word_r     <= 24'd0;
            csum_r     <= 8'd0;
        end else begin
            imem_we <= word_wr_s;
            // Release lags done by one cycle because it follows the registered state.
            core_hold <= (state_r != ST_DONE);
            if (word_wr_s) begin
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_wdata <= {rx_shift_r, word_r};
                word_cnt   <= word_cnt + 16'd1;
            end else if (frame_start_s) begin
                word_cnt <= 16'd0;
            end else begin
                word_cnt <= word_cnt;
            end
            if (frame_start_s)                        err <= 1'b0;
            else if (len_bad_s || csum_bad_s || ferr_s) err <= 1'b1;
            else                                      err <= err;
            if (csum_ok_s) done <= 1'b1;
            else           done <= done;
            if ((state_r == ST_LEN0) && byte_valid_s)      len_r[7:0]  <= rx_shift_r;
            else if ((state_r == ST_LEN1) && byte_valid_s) len_r[15:8] <= rx_shift_r;
            else                                           len_r       <= len_r;
            // Partial word is dropped by restarting the byte index.
            if (frame_start_s || ferr_s) begin
                byte_idx_r <= 2'd0;
            end else if (data_byte_s) begin
                byte_idx_r <= byte_idx_r + 2'd1;
                case (byte_idx_r)
                    2'd0:    word_r[7:0]   <= rx_shift_r;
                    2'd1:    word_r[15:8]  <= rx_shift_r;
                    2'd2:    word_r[23:16] <= rx_shift_r;
                    default: word_r        <= word_r;
                endcase
            end else begin
                byte_idx_r <= byte_idx_r;
            end
            if (frame_start_s)    csum_r <= 8'd0;
            else if (data_byte_s) csum_r <= csum_next(csum_r, rx_shift_r);
            else                  csum_r <= csum_r;
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed testbench for uart_boot_loader: drives UART frames byte by byte
// and compares RAM writes and status outputs with hand-computed values.
module tb_uart_boot_loader;

    localparam int CLK_DIV   = 4;
    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 4;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst;
    logic              uart_rx;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              err;
    logic [15:0]       word_cnt;

    uart_boot_loader #(
        .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_hold(core_hold), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write / status monitor, sampled on the falling edge.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int   we_b2b = 0;
    int   cyc = 0, done_cyc = -1, hold_cyc = -1;
    logic we_q = 1'b0, done_q = 1'b0, hold_q = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(32'(imem_addr));
            wr_data_q.push_back(imem_wdata);
            if (we_q) we_b2b++;
        end
        if (done && !done_q) done_cyc = cyc;
        if (!core_hold && hold_q) hold_cyc = cyc;
        we_q   = imem_we;
        done_q = done;
        hold_q = core_hold;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_seq(input bq_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
        repeat (6) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cyc = -1;
        hold_cyc = -1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_we"},    32'(imem_we),    32'd0);
        check_val({pfx, "_addr"},  32'(imem_addr),  32'd0);
        check_val({pfx, "_wdata"}, imem_wdata,      32'd0);
        check_val({pfx, "_hold"},  32'(core_hold),  32'd1);
        check_val({pfx, "_done"},  32'(done),       32'd0);
        check_val({pfx, "_err"},   32'(err),        32'd0);
        check_val({pfx, "_wcnt"},  32'(word_cnt),   32'd0);
    endtask

    task automatic check_good_load(input string pfx);
        check_val({pfx, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check_val({pfx, "_a0"}, wr_addr_q[0], 32'd0);
            check_val({pfx, "_d0"}, wr_data_q[0], 32'h0010_0013);
            check_val({pfx, "_a1"}, wr_addr_q[1], 32'd1);
            check_val({pfx, "_d1"}, wr_data_q[1], 32'h0020_0093);
        end
        check_val({pfx, "_wcnt"}, 32'(word_cnt),  32'd2);
        check_val({pfx, "_done"}, 32'(done),      32'd1);
        check_val({pfx, "_err"},  32'(err),       32'd0);
        check_val({pfx, "_hold"}, 32'(core_hold), 32'd0);
        check_val({pfx, "_hold_lag"}, 32'(hold_cyc - done_cyc), 32'd1);
    endtask

    bq_t good_q, bad_q, q;

    initial begin
        good_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
                   8'h93, 8'h00, 8'h20, 8'h00, 8'hB0};
        bad_q  = good_q;
        bad_q[11] = 8'hB1;
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Oversized length: rejected after LEN_HI, no writes.
        clear_log();
        q = '{8'hA5, 8'h05, 8'h00};
        send_seq(q);
        check_val("len_err",  32'(err),  32'd1);
        check_val("len_nwr",  32'(wr_addr_q.size()), 32'd0);
        check_val("len_done", 32'(done), 32'd0);

        // Framing error on the 5th data byte: only word 0 written.
        clear_log();
        q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00};
        send_seq(q);
        check_val("ferr_sync_clr", 32'(err), 32'd0);
        send_byte(8'h93, 1'b0);
        repeat (6) @(negedge clk);
        check_val("ferr_err",  32'(err),       32'd1);
        check_val("ferr_nwr",  32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check_val("ferr_a0", wr_addr_q[0], 32'd0);
            check_val("ferr_d0", wr_data_q[0], 32'h0010_0013);
        end
        check_val("ferr_wcnt", 32'(word_cnt),  32'd1);
        check_val("ferr_hold", 32'(core_hold), 32'd1);

        // Bad checksum: writes happen, err set, core stays held.
        clear_log();
        send_seq(bad_q);
        check_val("csum_nwr", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check_val("csum_a1", wr_addr_q[1], 32'd1);
            check_val("csum_d1", wr_data_q[1], 32'h0020_0093);
        end
        check_val("csum_err",  32'(err),       32'd1);
        check_val("csum_done", 32'(done),      32'd0);
        check_val("csum_hold", 32'(core_hold), 32'd1);
        check_val("csum_wcnt", 32'(word_cnt),  32'd2);

        // Correct frame loads and releases the core.
        clear_log();
        send_seq(good_q);
        check_good_load("good");

        // After done, further frames are ignored.
        clear_log();
        q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_seq(q);
        check_val("post_nwr",  32'(wr_addr_q.size()), 32'd0);
        check_val("post_done", 32'(done),      32'd1);
        check_val("post_err",  32'(err),       32'd0);
        check_val("post_wcnt", 32'(word_cnt),  32'd2);
        check_val("post_hold", 32'(core_hold), 32'd0);

        // Reset in the middle of a frame (sending stops mid-byte).
        q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10};
        foreach (q[i]) send_byte(q[i], 1'b1);
        uart_rx = 1'b0;
        repeat (2 * CLK_DIV) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Leading junk ignored, then a full correct frame.
        clear_log();
        q = '{8'h00, 8'hFF, 8'h12};
        send_seq(q);
        check_val("junk_nwr", 32'(wr_addr_q.size()), 32'd0);
        check_val("junk_err", 32'(err), 32'd0);
        send_seq(good_q);
        check_good_load("junk_good");

        check_val("we_spacing", 32'(we_b2b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Program loader sitting directly upstream of the instruction RAM inside the SoC memory controller.
- Receives a framed program image over a UART line and writes it word-by-word into instruction RAM.
- Holds the core in reset until the image passes its checksum, replacing bench-side memory preloading on silicon/FPGA.

Parameters:
- CLK_DIV, 16, clock cycles per UART bit (>=4, even).
- ADDR_W, 10, instruction RAM word-address width.
- MAX_WORDS, 1024, maximum accepted image length in 32-bit words (<= 2**ADDR_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- uart_rx  in  1  serial input, idle high, 8N1, LSB first.
- imem_we  out  1  instruction RAM write strobe, one-cycle pulse.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  write data.
- core_hold  out  1  1 = keep core in reset.
- done  out  1  image loaded and verified (sticky).
- err  out  1  last frame failed (sticky until the next sync byte).
- word_cnt  out  16  words written in the current frame.

Behaviour:
- Reset (async assert, sync release): imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, err=0, word_cnt=0, FSM=SYNC, UART RX idle.
- uart_rx passes through a 2-flop synchroniser (reset value 1).
- UART RX:
  - Start is detected on a synchronised 1->0 edge while idle.
  - Re-check at CLK_DIV/2; if high, treat as a glitch and return to idle.
  - Sample 8 data bits every CLK_DIV cycles, then the stop bit.
  - Stop=1: one-cycle byte_valid with the byte. Stop=0: framing error, goes to ERR handling.
- Frame format: 0xA5, LEN_LO, LEN_HI, then LEN*4 data bytes (little-endian per word), then CSUM = XOR of all data bytes.
- FSM states: SYNC, LEN0, LEN1, DATA, CSUM, DONE.
  - SYNC: non-0xA5 bytes are ignored. On 0xA5: err<=0, word_cnt<=0, running XOR<=0, go to LEN0.
  - LEN0/LEN1: capture LEN. After LEN1:
    - LEN>MAX_WORDS: err<=1, back to SYNC, no writes.
    - LEN=0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: shift bytes into the word, byte0 -> [7:0]. After the 4th byte:
    - Next cycle: imem_we=1 for exactly one cycle, imem_addr=word_cnt[ADDR_W-1:0], imem_wdata=assembled word.
    - word_cnt increments in the same cycle.
    - When word_cnt reaches LEN, go to CSUM.
  - CSUM:
    - Match: done<=1; core_hold<=0 on the following cycle; go to DONE.
    - Mismatch: err<=1, back to SYNC; core_hold stays 1; already-written words remain in RAM.
  - DONE: terminal state until rst. All further uart_rx activity is ignored, imem_we stays 0.
- Framing error in any state except DONE: err<=1, FSM<=SYNC, partial word discarded.
- Data already written before a failure is not rolled back; the next frame overwrites from address 0.
- A 0xA5 byte inside DATA/CSUM is treated as data, not as a resync.
- Reset mid-frame: all state is cleared immediately (async), including any partial word and partial UART byte; core_hold returns to 1.
- imem_we never asserts in two consecutive cycles; the minimum spacing is 4 UART bytes.

Test Plan:
1. CLK_DIV=4. Send A5 02 00 13 00 10 00 93 00 20 00 B0 -> writes addr0=0x00100013, addr1=0x00200093; word_cnt=2; done=1, err=0; core_hold drops 1 cycle after done.
2. Same frame with CSUM=B1 -> both writes occur; err=1, done=0, core_hold=1. A following correct frame then yields done=1.
3. MAX_WORDS=4. Send A5 05 00 -> err=1 after LEN_HI; no imem_we pulse; FSM back in SYNC.
4. Send 00 FF 12, then the frame from scenario 1 -> leading bytes ignored, identical result to scenario 1.
5. Stop bit driven 0 on the 5th data byte -> err=1; only addr0 written; word_cnt=1; core_hold=1.
6. Assert rst after 6 bytes of the scenario 1 frame -> all outputs return to reset values; a full frame afterwards loads correctly.
7. After done, send another frame -> no writes, outputs unchanged.
